// File: rtl/muu_repeat_scheduler.sv
// Round-robin job scheduler: grants one requester, configures the repeater, streams its block, waits for count*size output beats.
// Optional MUU_REPSCHED_STATS_EN builds a 32-bit completed-job counter on stat_jobs.
module muu_repeat_scheduler #(
  parameter int DATA_WIDTH = 512,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [8*NUM_REQ-1:0]          req_count,
  input  logic [8*NUM_REQ-1:0]          req_size,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] s_axis_tdata,
  input  logic [NUM_REQ-1:0]            s_axis_tvalid,
  output logic [NUM_REQ-1:0]            s_axis_tready,
  output logic [7:0]                    cfg_count,
  output logic [7:0]                    cfg_size,
  output logic                          cfg_valid,
  input  logic                          cfg_ready,
  output logic [DATA_WIDTH-1:0]         rep_tdata,
  output logic                          rep_tvalid,
  input  logic                          rep_tready,
  input  logic                          mon_tvalid,
  input  logic                          mon_tready,
  output logic [2:0]                    grant_id,
  output logic                          busy,
  output logic                          done_valid,
  output logic [2:0]                    done_id,
  output logic                          done_err,
  output logic [31:0]                   stat_jobs
);

  typedef enum logic [1:0] {IDLE, CFG, LOAD, RUN} state_t;

  state_t      state_q;
  logic [2:0]  grant_q, last_grant_q, done_id_q;
  logic [7:0]  count_q, size_q, load_cnt_q, load_cnt_d;
  logic [15:0] out_cnt_q, out_cnt_d, total;
  logic        cfg_valid_q, busy_q, done_valid_q, done_err_q;

  logic        found_hi, found_lo, accept;
  logic [2:0]  win_hi, win_lo, winner;
  logic [7:0]  win_count, win_size;
  logic        sel_tvalid, load_active, load_fire, load_last, mon_fire, complete;
  logic [DATA_WIDTH-1:0] sel_tdata;

  // Lowest index above last_grant wins; otherwise wrap to the lowest index overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_lo   = 3'(i);
        found_lo = 1'b1;
        if (3'(i) > last_grant_q) begin
          win_hi   = 3'(i);
          found_hi = 1'b1;
        end
      end
    end
    winner    = found_hi ? win_hi : win_lo;
    win_count = '0;
    win_size  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == 3'(i)) begin
        win_count = req_count[8*i +: 8];
        win_size  = req_size[8*i +: 8];
      end
    end
  end

  // The done cycle blocks acceptance so a grant never coincides with a completion pulse.
  assign accept = (state_q == IDLE) && !done_valid_q && found_lo && !rst;

  always_comb begin
    sel_tvalid = 1'b0;
    sel_tdata  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        sel_tvalid = s_axis_tvalid[i];
        sel_tdata  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign load_active = (state_q == LOAD);
  assign rep_tvalid  = load_active && sel_tvalid;
  assign rep_tdata   = load_active ? sel_tdata : '0;
  assign load_fire   = rep_tvalid && rep_tready;
  assign load_cnt_d  = load_cnt_q + 8'd1;
  assign load_last   = load_fire && (load_cnt_q == size_q - 8'd1);
  assign mon_fire    = mon_tvalid && mon_tready && (state_q == LOAD || state_q == RUN);
  assign out_cnt_d   = out_cnt_q + 16'(mon_fire);
  assign total       = 16'(count_q) * 16'(size_q);
  assign complete    = ((load_active && load_last) || state_q == RUN) && (out_cnt_d == total);

  always_comb begin
    req_ready     = '0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i]     = accept && (winner == 3'(i));
      s_axis_tready[i] = load_active && rep_tready && (grant_q == 3'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= 3'(NUM_REQ-1);
      count_q      <= '0;
      size_q       <= '0;
      load_cnt_q   <= '0;
      out_cnt_q    <= '0;
      cfg_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_id_q    <= '0;
    end else begin
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            grant_q      <= winner;
            last_grant_q <= winner;
            count_q      <= win_count;
            size_q       <= win_size;
            load_cnt_q   <= '0;
            out_cnt_q    <= '0;
            if (win_count == 8'd0 || win_size == 8'd0) begin
              done_valid_q <= 1'b1;
              done_err_q   <= 1'b1;
              done_id_q    <= winner;
            end else begin
              state_q     <= CFG;
              cfg_valid_q <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
        end
        CFG: begin
          if (cfg_ready) begin
            cfg_valid_q <= 1'b0;
            state_q     <= LOAD;
          end
        end
        LOAD, RUN: begin
          out_cnt_q <= out_cnt_d;
          if (load_fire) load_cnt_q <= load_cnt_d;
          if (complete) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_valid_q <= 1'b1;
            done_id_q    <= grant_q;
          end else if (load_last) begin
            state_q <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_count  = count_q;
  assign cfg_size   = size_q;
  assign cfg_valid  = cfg_valid_q;
  assign grant_id   = grant_q;
  assign busy       = busy_q;
  assign done_valid = done_valid_q;
  assign done_id    = done_id_q;
  assign done_err   = done_err_q;

`ifdef MUU_REPSCHED_STATS_EN
  logic [31:0] stat_jobs_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              stat_jobs_q <= '0;
    else if (done_valid_q && !done_err_q) stat_jobs_q <= stat_jobs_q + 32'd1;
  end
  assign stat_jobs = stat_jobs_q;
`else
  assign stat_jobs = '0;
`endif

endmodule

// File: doc/muu_repeat_scheduler.md
MUU_REPEAT_SCHEDULER -- requirements
Module: muu_repeat_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 512, stream data width.
REQ-002 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 clk  in  1  single clock, all logic on posedge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid / req_ready  in / out  NUM_REQ  per-requester job request handshake.
REQ-006 req_count / req_size  in  8*NUM_REQ  per-requester repetitions / words per block (slice i = bits 8i+7:8i).
REQ-007 s_axis_tdata / s_axis_tvalid / s_axis_tready  in / in / out  DATA_WIDTH*NUM_REQ / NUM_REQ / NUM_REQ  per-requester block-load streams.
REQ-008 cfg_count, cfg_size / cfg_valid / cfg_ready  out / out / in  8 each / 1 / 1  repeater configuration handshake.
REQ-009 rep_tdata / rep_tvalid / rep_tready  out / out / in  DATA_WIDTH / 1 / 1  load stream into the repeater.
REQ-010 mon_tvalid, mon_tready  in  1 each  tap of the repeater output handshake.
REQ-011 grant_id / busy  out  3 / 1  current owner index, job in progress.
REQ-012 done_valid / done_id / done_err  out  1 / 3 / 1  one-cycle job completion pulse, owner, zero-length flag.
REQ-013 stat_jobs  out  32  completed-job counter (see Configuration).

Function
REQ-014 FSM states IDLE, CFG, LOAD, RUN; reset state IDLE.
REQ-015 IDLE: if any req_valid, grant the round-robin winner, search from last_grant+1 upward, wrapping modulo NUM_REQ.
REQ-016 Acceptance: req_ready[winner] high for exactly one cycle in IDLE; count, size and id latched that cycle; busy=1 from the next cycle.
REQ-017 Accepted job with count==0 or size==0: no repeater access, stay IDLE, done_valid=1 with done_err=1 on the next cycle.
REQ-018 Otherwise go IDLE->CFG; cfg_valid=1 with latched values held stable until cfg_ready; on the handshake go to LOAD.
REQ-019 LOAD: rep_tdata = s_axis_tdata[grant]; rep_tvalid = s_axis_tvalid[grant]; s_axis_tready[grant] = rep_tready; all other s_axis_tready = 0.
REQ-020 LOAD: after size accepted beats, rep_tvalid and s_axis_tready deasserted in the same cycle as the last beat; go to RUN.
REQ-021 Output beat counter (16-bit) increments on every mon_tvalid & mon_tready from CFG exit onward; job total = count*size (max 65025, 16-bit unsigned, no overflow).
REQ-022 Completion when load finished and counter equals total (LOAD or RUN): done_valid=1 with done_id=grant and done_err=0; go to IDLE; busy=0.
REQ-023 Last load beat and final output beat in the same cycle: complete directly from LOAD.
REQ-024 A new acceptance is possible in the cycle after completion; same-cycle grant and done is forbidden.
REQ-025 last_grant updates only on acceptance; a requester that drops req_valid before acceptance is skipped.
REQ-026 mon handshakes while IDLE or CFG are ignored.
REQ-027 grant_id holds the last owner when idle.

Reset
REQ-028 rst asserted at any time, including mid-LOAD or mid-RUN, forces IDLE immediately. All handshake outputs, busy and done_valid go to 0. Counters, grant_id and stat_jobs go to 0; last_grant goes to NUM_REQ-1, so requester 0 has first priority.
REQ-029 The repeater shares rst; no flush sequence is issued after reset.

Configuration
REQ-030 Macro MUU_REPSCHED_STATS_EN defined: stat_jobs increments by 1 on each done_valid with done_err=0 and wraps at 2^32.
REQ-031 Macro undefined: stat_jobs is tied to 0 and no counter register is built.

Verification
REQ-032 Reset, then a single job from req1 with count=3, size=4: 4 beats are loaded, then 12 mon beats; done_valid pulses once with done_id=1, done_err=0.
REQ-033 req0..req3 all valid continuously with count=1, size=1: grants occur in order 0,1,2,3,0; each requester is served once per 4 jobs.
REQ-034 req2 with size=0: req_ready[2] pulses; the next cycle done_err=1; cfg_valid is never asserted.
REQ-035 cfg_ready held low for 10 cycles: cfg_valid and cfg_count/cfg_size stay stable; no s_axis_tready is asserted until the handshake.
REQ-036 rst pulsed mid-RUN, then a new job is issued: all outputs are 0 during reset; the new job completes normally and requester 0 wins first.
REQ-037 count=255, size=255 with MUU_REPSCHED_STATS_EN defined: done fires after exactly 65025 mon beats; stat_jobs=1.
